// File: rtl/oled_layer_compositor.sv
// Two-stage RGB565 layer compositor: priority pick of the first enabled, non-key layer
// over a background, with frame-shadowed enables, frame-counter blink and a valid flag.
module oled_layer_compositor #(
  parameter int                NUM_LAYERS = 4,
  parameter int                COL_W      = 16,
  parameter int                IDX_W      = 13,
  parameter logic [COL_W-1:0]  KEY_COL    = 16'h0000,
  parameter int                FC_W       = 8,
  parameter int                BLINK_BIT  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_begin,
  input  logic                        pix_valid_in,
  input  logic [IDX_W-1:0]            pixel_index,
  input  logic [NUM_LAYERS*COL_W-1:0] layer_col,
  input  logic [COL_W-1:0]            bg_col,
  input  logic [NUM_LAYERS-1:0]       layer_en_next,
  input  logic [NUM_LAYERS-1:0]       blink_req,
  output logic [COL_W-1:0]            pixel_out,
  output logic [IDX_W-1:0]            pixel_index_out,
  output logic                        pix_valid_out,
  output logic [3:0]                  hit_layer,
  output logic [FC_W-1:0]             frame_count
);

  localparam logic [3:0] BG_HIT = 4'(NUM_LAYERS);

  logic [NUM_LAYERS-1:0]       active_en_r;
  logic [FC_W-1:0]             frame_count_r;
  logic                        s1_valid_r;
  logic [IDX_W-1:0]            s1_index_r;
  logic [NUM_LAYERS*COL_W-1:0] s1_cols_r;
  logic [COL_W-1:0]            s1_bg_r;
  logic [NUM_LAYERS-1:0]       s1_mask_r;
  logic [COL_W-1:0]            pixel_out_r;
  logic [IDX_W-1:0]            pixel_index_out_r;
  logic                        pix_valid_out_r;
  logic [3:0]                  hit_layer_r;

  logic [NUM_LAYERS-1:0]       eff_mask_s;
  logic [NUM_LAYERS-1:0]       qual_s;
  logic [COL_W-1:0]            win_col_s;
  logic [3:0]                  win_hit_s;

  // Mask uses pre-update enables and phase, so a pixel alongside frame_begin sees the old frame.
  assign eff_mask_s = active_en_r & ~(blink_req & {NUM_LAYERS{frame_count_r[BLINK_BIT]}});

  // Frame-boundary state: shadowed enables and the wrapping frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_en_r   <= {NUM_LAYERS{1'b1}};
      frame_count_r <= {FC_W{1'b0}};
    end else if (frame_begin) begin
      active_en_r   <= layer_en_next;
      frame_count_r <= frame_count_r + {{(FC_W-1){1'b0}}, 1'b1};
    end else begin
      active_en_r   <= active_en_r;
      frame_count_r <= frame_count_r;
    end
  end

  // Stage 1: capture the pixel, its layers and the effective mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_index_r <= {IDX_W{1'b0}};
      s1_cols_r  <= {(NUM_LAYERS*COL_W){1'b0}};
      s1_bg_r    <= {COL_W{1'b0}};
      s1_mask_r  <= {NUM_LAYERS{1'b0}};
    end else begin
      s1_valid_r <= pix_valid_in;
      s1_index_r <= pixel_index;
      s1_cols_r  <= layer_col;
      s1_bg_r    <= bg_col;
      s1_mask_r  <= eff_mask_s;
    end
  end

  // Priority select: scanning from the lowest priority upward lets layer 0 overwrite last.
  always_comb begin
    qual_s    = {NUM_LAYERS{1'b0}};
    win_col_s = s1_bg_r;
    win_hit_s = BG_HIT;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      qual_s[i] = s1_mask_r[i] & (s1_cols_r[i*COL_W +: COL_W] != KEY_COL);
      win_col_s = qual_s[i] ? s1_cols_r[i*COL_W +: COL_W] : win_col_s;
      win_hit_s = qual_s[i] ? 4'(i) : win_hit_s;
    end
  end

  // Stage 2: registered outputs; colour, index and hit hold across invalid cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_valid_out_r   <= 1'b0;
      pixel_out_r       <= {COL_W{1'b0}};
      pixel_index_out_r <= {IDX_W{1'b0}};
      hit_layer_r       <= 4'd0;
    end else if (s1_valid_r) begin
      pix_valid_out_r   <= 1'b1;
      pixel_out_r       <= win_col_s;
      pixel_index_out_r <= s1_index_r;
      hit_layer_r       <= win_hit_s;
    end else begin
      pix_valid_out_r   <= 1'b0;
      pixel_out_r       <= pixel_out_r;
      pixel_index_out_r <= pixel_index_out_r;
      hit_layer_r       <= hit_layer_r;
    end
  end

  assign pixel_out       = pixel_out_r;
  assign pixel_index_out = pixel_index_out_r;
  assign pix_valid_out   = pix_valid_out_r;
  assign hit_layer       = hit_layer_r;
  assign frame_count     = frame_count_r;

endmodule

// File: tb/tb_oled_layer_compositor.sv
// Randomised and directed scoreboard bench for oled_layer_compositor at default parameters.
module tb_oled_layer_compositor;

  localparam int NL = 4;
  localparam int CW = 16;
  localparam int IW = 13;
  localparam int FW = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           frame_begin = 1'b0;
  logic           pix_valid_in = 1'b0;
  logic [IW-1:0]  pixel_index = '0;
  logic [NL*CW-1:0] layer_col = '0;
  logic [CW-1:0]  bg_col = '0;
  logic [NL-1:0]  layer_en_next = 4'hF;
  logic [NL-1:0]  blink_req = 4'h0;
  logic [CW-1:0]  pixel_out;
  logic [IW-1:0]  pixel_index_out;
  logic           pix_valid_out;
  logic [3:0]     hit_layer;
  logic [FW-1:0]  frame_count;

  oled_layer_compositor dut (
    .clk(clk), .reset(reset), .frame_begin(frame_begin), .pix_valid_in(pix_valid_in),
    .pixel_index(pixel_index), .layer_col(layer_col), .bg_col(bg_col),
    .layer_en_next(layer_en_next), .blink_req(blink_req), .pixel_out(pixel_out),
    .pixel_index_out(pixel_index_out), .pix_valid_out(pix_valid_out),
    .hit_layer(hit_layer), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] col;
    logic [3:0]    hit;
    logic [IW-1:0] idx;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_fc = 0;
  logic [NL-1:0] model_en = 4'hF;
  logic [CW-1:0] last_col = '0;
  logic [3:0]    last_hit = '0;
  logic [IW-1:0] last_idx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the highest-priority visible layer whose colour is not the key, else background.
  function automatic void ref_pix(input logic [NL*CW-1:0] cols, input logic [CW-1:0] bg,
                                  input logic [NL-1:0] mask,
                                  output logic [CW-1:0] c, output logic [3:0] h);
    logic [CW-1:0] lc;
    c = bg;
    h = 4'(NL);
    for (int i = 0; i < NL; i++) begin
      lc = cols[i*CW +: CW];
      if (mask[i] && lc != 16'h0000) begin
        c = lc;
        h = 4'(i);
        break;
      end
    end
  endfunction

  task automatic drive(input bit v, input logic [IW-1:0] idx, input logic [NL*CW-1:0] cols,
                       input logic [CW-1:0] bg, input bit fb, input logic [NL-1:0] en_next,
                       input logic [NL-1:0] blink);
    exp_t e;
    logic [NL-1:0] hidden;
    pix_valid_in  = v;
    pixel_index   = idx;
    layer_col     = cols;
    bg_col        = bg;
    frame_begin   = fb;
    layer_en_next = en_next;
    blink_req     = blink;
    if (v) begin
      hidden = (((model_fc % 256) / 4) % 2 == 1) ? blink : 4'h0;
      ref_pix(cols, bg, model_en & ~hidden, e.col, e.hit);
      e.idx = idx;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    if (fb) begin
      model_fc++;
      model_en = en_next;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, 1'b0, model_en, 4'h0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    pix_valid_in = 1'b0;
    frame_begin = 1'b0;
    sb.delete();
    model_fc = 0;
    model_en = 4'hF;
    last_col = '0;
    last_hit = '0;
    last_idx = '0;
    #1;
    chk("valid_at_reset", 32'(pix_valid_out), 32'd0);
    repeat (n) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [CW-1:0] rand_col();
    return ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
  endfunction

  // Monitor: pop the scoreboard on every valid output, check hold and counter otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("valid_in_reset", 32'(pix_valid_out), 32'd0);
    end else if (pix_valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pixel: got index %0d expected none", pixel_index_out);
      end else begin
        e = sb.pop_front();
        chk("pixel_out", 32'(pixel_out), 32'(e.col));
        chk("hit_layer", 32'(hit_layer), 32'(e.hit));
        chk("pixel_index_out", 32'(pixel_index_out), 32'(e.idx));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
        last_col = e.col;
        last_hit = e.hit;
        last_idx = e.idx;
      end
    end else begin
      chk("hold_col", 32'(pixel_out), 32'(last_col));
      chk("hold_hit", 32'(hit_layer), 32'(last_hit));
      chk("hold_idx", 32'(pixel_index_out), 32'(last_idx));
    end
    chk("frame_count", 32'(frame_count), 32'(model_fc % 256));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NL*CW-1:0] pri_cols;
    pri_cols = {16'h001F, 16'h07E0, 16'h0000, 16'hF800};

    do_reset(3);
    @(negedge clk);
    chk("reset_pixel_out", 32'(pixel_out), 32'd0);
    chk("reset_index_out", 32'(pixel_index_out), 32'd0);
    chk("reset_valid_out", 32'(pix_valid_out), 32'd0);
    chk("reset_hit", 32'(hit_layer), 32'd0);
    chk("reset_frame_count", 32'(frame_count), 32'd0);
    @(posedge clk); #1;

    drive(1'b1, 13'd5, '0, '0, 1'b0, 4'hF, 4'h0);
    idle(3);

    // Priority
    drive(1'b1, 13'd10, pri_cols, 16'h1234, 1'b0, 4'hF, 4'h0);
    drive(1'b1, 13'd11, {16'h001F, 16'h07E0, 16'h0000, 16'h0000}, 16'h1234, 1'b0, 4'hF, 4'h0);
    drive(1'b1, 13'd12, '0, 16'h1234, 1'b0, 4'hF, 4'h0);
    idle(2);

    // Enable shadowing: L0 disabled only from the frame after the pulse
    drive(1'b1, 13'd20, pri_cols, 16'h1234, 1'b0, 4'b1110, 4'h0);
    drive(1'b1, 13'd21, pri_cols, 16'h1234, 1'b0, 4'b1110, 4'h0);
    drive(1'b1, 13'd22, pri_cols, 16'h1234, 1'b1, 4'b1110, 4'h0);
    drive(1'b1, 13'd23, pri_cols, 16'h1234, 1'b0, 4'b1110, 4'h0);
    idle(2);

    // Blink on L0 across several phase changes
    drive(1'b0, '0, pri_cols, 16'h1234, 1'b1, 4'hF, 4'b0001);
    for (int f = 0; f < 12; f++) begin
      drive(1'b1, 13'(100 + f), pri_cols, 16'h1234, 1'b0, 4'hF, 4'b0001);
      drive(1'b1, 13'(200 + f), pri_cols, 16'h1234, 1'b1, 4'hF, 4'b0001);
    end
    idle(2);

    // Frame counter wrap with changing enables
    for (int f = 0; f < 256; f++) begin
      drive(1'b0, '0, '0, '0, 1'b1, 4'($urandom), 4'h0);
      drive(1'b1, 13'(f), {rand_col(), rand_col(), rand_col(), rand_col()},
            16'($urandom), 1'b0, 4'hF, 4'($urandom));
    end
    idle(2);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 13'($urandom_range(0, 6143)),
            {rand_col(), rand_col(), rand_col(), rand_col()},
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom));
    end
    idle(3);

    // Reset mid-stream after enables were narrowed
    drive(1'b0, '0, '0, '0, 1'b1, 4'b1110, 4'h0);
    for (int k = 0; k < 4; k++) drive(1'b1, 13'(300 + k), pri_cols, 16'h1234, 1'b0, 4'b1110, 4'h0);
    do_reset(2);
    for (int k = 4; k < 10; k++) drive(1'b1, 13'(300 + k), pri_cols, 16'h1234, 1'b0, 4'b1110, 4'h0);
    idle(4);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
